// File: rtl/dequant_pkg.sv
// Shared types and constants for the int8 -> int32 dequantizer.
// Imported by the pipeline datapath and the job-control top.
package dequant_pkg;

  localparam int PROD_WIDTH = 8 + 32 + 1;
  localparam int ROUND_CONST = 1 << (16 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dequant_pipe.sv
// Two-stage multiply / round datapath with valid-ready flow control.
// Each stage carries its own valid bit and the last tag travels with data.
module dequant_pipe
  import dequant_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 32,
  parameter int SCALE_FRAC  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SCALE_WIDTH-1:0]      scale,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_last
);

  localparam int PW = DATA_WIDTH + SCALE_WIDTH + 1;
  localparam logic signed [PW-1:0] RND =
    {{(PW-1){1'b0}}, 1'b1} << (SCALE_FRAC - 1);

  logic                        s1_valid;
  logic                        s1_last;
  logic signed [PW-1:0]        s1_prod;
  logic                        s2_valid;
  logic                        s2_last;
  logic signed [ACC_WIDTH-1:0] s2_data;
  logic                        s1_adv;
  logic                        s2_adv;
  logic signed [PW-1:0]        op_a;
  logic signed [PW-1:0]        op_b;
  logic signed [PW-1:0]        prod;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // scale is unsigned, so it enters the signed product zero-extended
  assign op_a = {{(PW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign op_b = {{(PW-SCALE_WIDTH){1'b0}}, scale};
  assign prod = op_a * op_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod <= prod;
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= ACC_WIDTH'((s1_prod + RND) >>> SCALE_FRAC);
        s2_last <= s1_last;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_last  = s2_valid && s2_last;

endmodule

// File: rtl/dequantizer_stream.sv
// Streaming int8 -> int32 dequantizer job engine.
// Owns the job FSM, element counter and start/done handshake.
module dequantizer_stream
  import dequant_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 32,
  parameter int SCALE_FRAC  = 16,
  parameter int MAX_LEN     = 128,
  parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SCALE_WIDTH-1:0]      scale,
  input  logic [LEN_WIDTH-1:0]        length,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        done
);

  state_t                 state;
  state_t                 state_nxt;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [LEN_WIDTH-1:0]   length_q;
  logic [LEN_WIDTH-1:0]   accept_cnt;
  logic                   pipe_ready;
  logic                   take;
  logic                   in_fire;
  logic                   in_last;
  logic                   last_fire;

  assign take      = (state == RUN) && (accept_cnt < length_q) && pipe_ready;
  assign in_ready  = take;
  assign in_fire   = in_valid && take;
  assign in_last   = (accept_cnt + LEN_WIDTH'(1)) == length_q;
  assign last_fire = out_valid && out_ready && out_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN:     if (in_fire && in_last) state_nxt = DRAIN;
      DRAIN:   if (last_fire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      scale_q    <= '0;
      length_q   <= '0;
      accept_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        scale_q    <= scale;
        length_q   <= length;
        accept_cnt <= '0;
      end else if (in_fire) begin
        accept_cnt <= accept_cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  dequant_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SCALE_WIDTH (SCALE_WIDTH),
    .SCALE_FRAC  (SCALE_FRAC)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .scale     (scale_q),
    .in_valid  (in_fire),
    .in_ready  (pipe_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_dequantizer_stream.sv
// Directed testbench for dequantizer_stream.
// Hand-computed vectors, one task per scenario.
module tb_dequantizer_stream;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [31:0]        scale = '0;
  logic [7:0]         length = '0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_data;
  logic               out_last;
  logic               done;

  int ncmp = 0;
  int errs = 0;
  int cyc = 0;

  logic signed [31:0] got_q[$];
  logic               lst_q[$];
  int                 xfer_cyc[$];
  int                 acc_cyc[$];
  int                 done_cyc[$];

  logic [7:0]         fd[8];
  logic signed [31:0] ex[8];

  dequantizer_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .scale     (scale),
    .length    (length),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        lst_q.push_back(out_last);
        xfer_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic start_job(input logic [31:0] sc, input logic [7:0] len);
    @(negedge clk);
    start = 1'b1;
    scale = sc;
    length = len;
    @(negedge clk);
    start = 1'b0;
    scale = 32'hDEAD_BEEF;
    length = 8'd7;
  endtask

  task automatic feed(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = fd[i];
      #1;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (!in_ready) begin
        ncmp++; errs++;
        $display("FAIL feed_timeout elem=%0d in_ready=%0b required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int dbase, input int budget);
    int t;
    t = 0;
    while (done_cyc.size() <= dbase && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (done_cyc.size() <= dbase) begin
      ncmp++; errs++;
      $display("FAIL done_timeout got=%0d dones required %0d", done_cyc.size() - dbase, 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    ncmp++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    ncmp++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    ncmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    ncmp++; if (out_data !== 32'sd0) begin errs++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
    ncmp++; if (out_last !== 1'b0) begin errs++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    ncmp++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    ncmp++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_identity();
    int gb, ab, db;
    gb = got_q.size(); ab = acc_cyc.size(); db = done_cyc.size();
    fd = '{8'd5, 8'hF9, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{32'sd5, -32'sd7, 32'sd0, 32'sd127, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    start_job(32'h0001_0000, 8'd4);
    feed(4);
    wait_done(db, 50);
    repeat (3) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 4) begin
      errs++; $display("FAIL id_count got=%0d exp=4", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL id_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
        ncmp++;
        if (lst_q[gb+i] !== (i == 3)) begin
          errs++; $display("FAIL id_last[%0d] got=%b exp=%b", i, lst_q[gb+i], i == 3);
        end
      end
      ncmp++;
      if (xfer_cyc[gb] - acc_cyc[ab] !== 2) begin
        errs++; $display("FAIL id_latency got=%0d exp=2", xfer_cyc[gb] - acc_cyc[ab]);
      end
      ncmp++;
      if (done_cyc.size() - db !== 1) begin
        errs++; $display("FAIL id_done_count got=%0d exp=1", done_cyc.size() - db);
      end else begin
        ncmp++;
        if (done_cyc[db] - xfer_cyc[gb+3] !== 1) begin
          errs++; $display("FAIL id_done_delay got=%0d exp=1", done_cyc[db] - xfer_cyc[gb+3]);
        end
      end
    end
  endtask

  task automatic test_round_half();
    int gb, db;
    gb = got_q.size(); db = done_cyc.size();
    fd = '{8'd3, 8'hFD, 8'd1, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{32'sd2, -32'sd1, 32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    start_job(32'h0000_8000, 8'd4);
    feed(4);
    wait_done(db, 50);
    repeat (2) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 4) begin
      errs++; $display("FAIL half_count got=%0d exp=4", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL half_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_wide_scale();
    int gb, db;
    gb = got_q.size(); db = done_cyc.size();
    fd = '{8'd127, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{32'sd32512, -32'sd32768, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    start_job(32'h0100_0000, 8'd2);
    feed(2);
    wait_done(db, 50);
    repeat (2) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 2) begin
      errs++; $display("FAIL wide_count got=%0d exp=2", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL wide_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int gb, db;
    logic signed [31:0] hold;
    gb = got_q.size(); db = done_cyc.size();
    fd = '{8'd10, 8'hEC, 8'd30, 8'hD8, 8'd50, 8'hC4, 8'd0, 8'd0};
    ex = '{32'sd20, -32'sd40, 32'sd60, -32'sd80, 32'sd100, -32'sd120, 32'sd0, 32'sd0};
    out_ready = 1'b1;
    start_job(32'h0002_0000, 8'd6);
    fork
      feed(6);
      begin
        int t;
        t = 0;
        while (got_q.size() <= gb && t < 100) begin
          @(negedge clk);
          t++;
        end
        out_ready = 1'b0;
        #1;
        hold = out_data;
        ncmp++;
        if (hold !== -32'sd40) begin
          errs++; $display("FAIL bp_head got=%0d exp=-40", hold);
        end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #1;
          end
          ncmp++;
          if (out_valid !== 1'b1) begin
            errs++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid);
          end
          ncmp++;
          if (out_data !== hold) begin
            errs++; $display("FAIL bp_stable[%0d] got=%0d exp=%0d", k, out_data, hold);
          end
          ncmp++;
          if (in_ready !== 1'b0) begin
            errs++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_done(db, 60);
    repeat (2) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 6) begin
      errs++; $display("FAIL bp_count got=%0d exp=6", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
      end
      ncmp++;
      if (lst_q[gb+5] !== 1'b1) begin
        errs++; $display("FAIL bp_last got=%b exp=1", lst_q[gb+5]);
      end
    end
  endtask

  task automatic test_zero_length();
    int gb, db;
    gb = got_q.size(); db = done_cyc.size();
    start_job(32'h0001_0000, 8'd0);
    #1;
    ncmp++; if (done !== 1'b1) begin errs++; $display("FAIL zl_done got=%b exp=1", done); end
    ncmp++; if (busy !== 1'b1) begin errs++; $display("FAIL zl_busy got=%b exp=1", busy); end
    @(negedge clk);
    #1;
    ncmp++; if (done !== 1'b0) begin errs++; $display("FAIL zl_done_end got=%b exp=0", done); end
    ncmp++; if (busy !== 1'b0) begin errs++; $display("FAIL zl_idle got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    ncmp++;
    if (done_cyc.size() - db !== 1) begin
      errs++; $display("FAIL zl_done_count got=%0d exp=1", done_cyc.size() - db);
    end
    ncmp++;
    if (got_q.size() - gb !== 0) begin
      errs++; $display("FAIL zl_outputs got=%0d exp=0", got_q.size() - gb);
    end
  endtask

  task automatic test_start_ignored();
    int gb, db;
    gb = got_q.size(); db = done_cyc.size();
    fd = '{8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{32'sd4, 32'sd5, 32'sd6, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    start_job(32'h0001_0000, 8'd3);
    @(negedge clk);
    start = 1'b1;
    scale = 32'h0003_0000;
    length = 8'd1;
    @(negedge clk);
    start = 1'b0;
    #1;
    ncmp++; if (busy !== 1'b1) begin errs++; $display("FAIL si_busy got=%b exp=1", busy); end
    feed(3);
    wait_done(db, 50);
    repeat (2) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 3) begin
      errs++; $display("FAIL si_count got=%0d exp=3", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL si_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
      end
      ncmp++;
      if (lst_q[gb+2] !== 1'b1) begin
        errs++; $display("FAIL si_last got=%b exp=1", lst_q[gb+2]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int gb, db;
    db = done_cyc.size();
    fd = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd0, 8'd0, 8'd0, 8'd0};
    out_ready = 1'b0;
    start_job(32'h0001_0000, 8'd4);
    feed(2);
    #1;
    ncmp++;
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL mr_inflight got=%b exp=1", out_valid);
    end
    rst = 1'b1;
    #1;
    ncmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mr_out_valid got=%b exp=0", out_valid); end
    ncmp++; if (out_data !== 32'sd0) begin errs++; $display("FAIL mr_out_data got=%0d exp=0", out_data); end
    ncmp++; if (busy !== 1'b0) begin errs++; $display("FAIL mr_busy got=%b exp=0", busy); end
    ncmp++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mr_in_ready got=%b exp=0", in_ready); end
    ncmp++; if (out_last !== 1'b0) begin errs++; $display("FAIL mr_out_last got=%b exp=0", out_last); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    ncmp++;
    if (done_cyc.size() - db !== 0) begin
      errs++; $display("FAIL mr_no_done got=%0d exp=0", done_cyc.size() - db);
    end
    gb = got_q.size(); db = done_cyc.size();
    fd = '{8'd9, 8'hF7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{32'sd9, -32'sd9, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    start_job(32'h0001_0000, 8'd2);
    feed(2);
    wait_done(db, 50);
    repeat (2) @(negedge clk);
    ncmp++;
    if (got_q.size() - gb !== 2) begin
      errs++; $display("FAIL mr_count got=%0d exp=2", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (got_q[gb+i] !== ex[i]) begin
          errs++; $display("FAIL mr_data[%0d] got=%0d exp=%0d", i, got_q[gb+i], ex[i]);
        end
      end
    end
    ncmp++;
    if (done_cyc.size() - db !== 1) begin
      errs++; $display("FAIL mr_done_count got=%0d exp=1", done_cyc.size() - db);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_round_half();
    test_wide_scale();
    test_backpressure();
    test_zero_length();
    test_start_ignored();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, errs);
    $finish;
  end

endmodule
